// File: rtl/axis_weight_memory_writer.sv
// Streams weight beats into N_BANKS memory banks, one word per cycle, round-robin.
// Beat latency: word k strobes k+1 cycles after the handshake; ready is held low while unpacking.
module axis_weight_memory_writer #(
  parameter  int AXIS_BUS_BIT_WIDTH    = 64,
  parameter  int WEIGHT_WORD_BIT_WIDTH = 16,
  parameter  int N_BANKS               = 4,
  parameter  int BANK_DEPTH            = 512,
  localparam int WORDS_PER_BEAT        = AXIS_BUS_BIT_WIDTH / WEIGHT_WORD_BIT_WIDTH,
  localparam int ADDR_W                = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1,
  localparam int CNT_W                 = $clog2(N_BANKS * BANK_DEPTH + 1)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             clear,
  input  logic [AXIS_BUS_BIT_WIDTH-1:0]    s_axis_data,
  input  logic                             s_axis_valid,
  input  logic                             s_axis_last,
  output logic                             s_axis_ready,
  output logic [N_BANKS-1:0]               wm_wr_en,
  output logic [ADDR_W-1:0]                wm_wr_addr,
  output logic [WEIGHT_WORD_BIT_WIDTH-1:0] wm_wr_data,
  output logic                             done,
  output logic                             overflow,
  output logic [CNT_W-1:0]                 words_written
);

  localparam int BANK_W = (N_BANKS > 1) ? $clog2(N_BANKS) : 1;
  localparam int IDX_W  = (WORDS_PER_BEAT > 1) ? $clog2(WORDS_PER_BEAT) : 1;

  localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(N_BANKS - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BANK_DEPTH - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(WORDS_PER_BEAT - 1);
  localparam logic [CNT_W-1:0]  MAX_WORDS = CNT_W'(N_BANKS * BANK_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UNPACK = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                          state;
  logic [AXIS_BUS_BIT_WIDTH-1:0]   data_q;
  logic                            beat_last;
  logic [IDX_W-1:0]                word_idx;
  logic [BANK_W-1:0]               bank_ptr;
  logic [ADDR_W-1:0]               addr_ptr;
  logic                            full;
  logic [N_BANKS-1:0]              bank_onehot;

  assign s_axis_ready = (state == IDLE) && !clear;
  assign bank_onehot  = N_BANKS'(1) << bank_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      data_q        <= '0;
      beat_last     <= 1'b0;
      word_idx      <= '0;
      bank_ptr      <= '0;
      addr_ptr      <= '0;
      full          <= 1'b0;
      wm_wr_en      <= '0;
      wm_wr_addr    <= '0;
      wm_wr_data    <= '0;
      done          <= 1'b0;
      overflow      <= 1'b0;
      words_written <= '0;
    end else begin
      wm_wr_en <= '0;
      done     <= 1'b0;
      if (clear) begin
        state         <= IDLE;
        beat_last     <= 1'b0;
        word_idx      <= '0;
        bank_ptr      <= '0;
        addr_ptr      <= '0;
        full          <= 1'b0;
        overflow      <= 1'b0;
        words_written <= '0;
      end else begin
        case (state)
          IDLE: begin
            // ready equals ~clear here, and clear is low on this branch
            if (s_axis_valid) begin
              data_q    <= s_axis_data;
              beat_last <= s_axis_last;
              word_idx  <= '0;
              state     <= UNPACK;
            end
          end

          UNPACK: begin
            // the current word always sits in the low bits of the shift register
            data_q <= data_q >> WEIGHT_WORD_BIT_WIDTH;
            if (!full) begin
              wm_wr_en   <= bank_onehot;
              wm_wr_addr <= addr_ptr;
              wm_wr_data <= data_q[WEIGHT_WORD_BIT_WIDTH-1:0];
              if (words_written != MAX_WORDS) begin
                words_written <= words_written + CNT_W'(1);
              end
              if (bank_ptr == LAST_BANK) begin
                // pointers park on the last location once memory is full
                if (addr_ptr == LAST_ADDR) begin
                  full <= 1'b1;
                end else begin
                  bank_ptr <= '0;
                  addr_ptr <= addr_ptr + ADDR_W'(1);
                end
              end else begin
                bank_ptr <= bank_ptr + BANK_W'(1);
              end
            end else begin
              overflow <= 1'b1;
            end
            if (word_idx == LAST_IDX) begin
              state <= beat_last ? DONE : IDLE;
            end else begin
              word_idx <= word_idx + IDX_W'(1);
            end
          end

          DONE: begin
            done     <= 1'b1;
            bank_ptr <= '0;
            addr_ptr <= '0;
            word_idx <= '0;
            full     <= 1'b0;
            state    <= IDLE;
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_axis_weight_memory_writer.sv
// Scoreboard bench: stimulus queues expected bank writes, a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_axis_weight_memory_writer;

  typedef struct {
    logic [3:0]  en;
    logic [8:0]  addr;
    logic [15:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // instance A: default geometry
  logic        clear_a, valid_a, last_a, ready_a, done_a, ovf_a;
  logic [63:0] data_a;
  logic [3:0]  en_a;
  logic [8:0]  addr_a;
  logic [15:0] wdata_a;
  logic [11:0] ww_a;

  // instance B: two-deep banks to reach the full condition
  logic        clear_b, valid_b, last_b, ready_b, done_b, ovf_b;
  logic [63:0] data_b;
  logic [3:0]  en_b;
  logic [0:0]  addr_b;
  logic [15:0] wdata_b;
  logic [3:0]  ww_b;

  axis_weight_memory_writer dut_a (
    .clk(clk), .reset(reset), .clear(clear_a),
    .s_axis_data(data_a), .s_axis_valid(valid_a), .s_axis_last(last_a), .s_axis_ready(ready_a),
    .wm_wr_en(en_a), .wm_wr_addr(addr_a), .wm_wr_data(wdata_a),
    .done(done_a), .overflow(ovf_a), .words_written(ww_a)
  );

  axis_weight_memory_writer #(.BANK_DEPTH(2)) dut_b (
    .clk(clk), .reset(reset), .clear(clear_b),
    .s_axis_data(data_b), .s_axis_valid(valid_b), .s_axis_last(last_b), .s_axis_ready(ready_b),
    .wm_wr_en(en_b), .wm_wr_addr(addr_b), .wm_wr_data(wdata_b),
    .done(done_b), .overflow(ovf_b), .words_written(ww_b)
  );

  exp_t exp_a[$];
  exp_t exp_b[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   done_cnt_a = 0;
  int   done_cnt_b = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_a(input int bank, input int addr, input logic [15:0] d);
    exp_t e;
    e.en = 4'(1 << bank); e.addr = 9'(addr); e.data = d;
    exp_a.push_back(e);
  endtask

  task automatic push_b(input int bank, input int addr, input logic [15:0] d);
    exp_t e;
    e.en = 4'(1 << bank); e.addr = 9'(addr); e.data = d;
    exp_b.push_back(e);
  endtask

  // monitor: samples exactly on the negedge, stimulus acts 1ns later
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      if (done_a) done_cnt_a++;
      if (done_b) done_cnt_b++;
      if (en_a != 4'b0) begin
        if (exp_a.size() == 0) check("unexpected_write_a", {60'b0, en_a}, 64'h0);
        else begin
          exp_t e;
          e = exp_a.pop_front();
          check("wr_en_a", {60'b0, en_a}, {60'b0, e.en});
          check("wr_addr_a", {55'b0, addr_a}, {55'b0, e.addr});
          check("wr_data_a", {48'b0, wdata_a}, {48'b0, e.data});
        end
      end
      if (en_b != 4'b0) begin
        if (exp_b.size() == 0) check("unexpected_write_b", {60'b0, en_b}, 64'h0);
        else begin
          exp_t e;
          e = exp_b.pop_front();
          check("wr_en_b", {60'b0, en_b}, {60'b0, e.en});
          check("wr_addr_b", {63'b0, addr_b}, {55'b0, e.addr});
          check("wr_data_b", {48'b0, wdata_b}, {48'b0, e.data});
        end
      end
    end
  end

  task automatic send_a(input logic [63:0] d, input logic l);
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      valid_a = 1'b1; data_a = d; last_a = l;
      if (ready_a) begin ok = 1'b1; break; end
    end
    check("handshake_a", {63'b0, ok}, 64'h1);
    @(posedge clk);
    #1;
    valid_a = 1'b0; last_a = 1'b0; data_a = 64'hDEAD_BEEF_DEAD_BEEF;
  endtask

  task automatic send_b(input logic [63:0] d, input logic l);
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      valid_b = 1'b1; data_b = d; last_b = l;
      if (ready_b) begin ok = 1'b1; break; end
    end
    check("handshake_b", {63'b0, ok}, 64'h1);
    @(posedge clk);
    #1;
    valid_b = 1'b0; last_b = 1'b0; data_b = 64'hDEAD_BEEF_DEAD_BEEF;
  endtask

  task automatic wait_done_a();
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done_a) begin seen = 1'b1; break; end
    end
    check("done_seen_a", {63'b0, seen}, 64'h1);
  endtask

  task automatic wait_done_b();
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done_b) begin seen = 1'b1; break; end
    end
    check("done_seen_b", {63'b0, seen}, 64'h1);
  endtask

  task automatic pulse_clear_a();
    tick(); clear_a = 1'b1;
    tick(); clear_a = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, t0, t1, hs;
    logic [63:0] beat;
    logic [63:0] bp_beats [2];

    reset = 1'b1;
    clear_a = 1'b0; valid_a = 1'b0; last_a = 1'b0; data_a = '0;
    clear_b = 1'b0; valid_b = 1'b0; last_b = 1'b0; data_b = '0;
    repeat (2) tick();
    reset = 1'b0;
    tick();

    // reset state
    check("rst_ready", {63'b0, ready_a}, 64'h1);
    check("rst_en", {60'b0, en_a}, 64'h0);
    check("rst_addr", {55'b0, addr_a}, 64'h0);
    check("rst_data", {48'b0, wdata_a}, 64'h0);
    check("rst_done", {63'b0, done_a}, 64'h0);
    check("rst_ovf", {63'b0, ovf_a}, 64'h0);
    check("rst_ww", {52'b0, ww_a}, 64'h0);
    check("rst_ready_b", {63'b0, ready_b}, 64'h1);

    // basic single beat
    push_a(0, 0, 16'h1111); push_a(1, 0, 16'h2222);
    push_a(2, 0, 16'h3333); push_a(3, 0, 16'h4444);
    send_a(64'h4444_3333_2222_1111, 1'b1);
    tick();
    check("no_strobe_before_latency", {60'b0, en_a}, 64'h0);
    tick();
    check("first_strobe_latency", {60'b0, en_a}, 64'h1);
    check("ready_low_in_unpack", {63'b0, ready_a}, 64'h0);
    repeat (3) tick();
    check("done_not_early", {63'b0, done_a}, 64'h0);
    tick();
    check("done_pulse", {63'b0, done_a}, 64'h1);
    tick();
    check("done_one_cycle", {63'b0, done_a}, 64'h0);
    check("basic_ww", {52'b0, ww_a}, 64'd4);

    // round-robin wrap across three addresses
    pulse_clear_a();
    d0 = done_cnt_a;
    for (int b = 0; b < 3; b++) begin
      for (int w = 0; w < 4; w++) begin
        beat[w*16 +: 16] = 16'(16'h1000 * (b + 1) + w + 1);
        push_a(w, b, 16'(16'h1000 * (b + 1) + w + 1));
      end
      send_a(beat, b == 2);
    end
    wait_done_a();
    repeat (3) tick();
    check("wrap_done_once", done_cnt_a, d0 + 1);
    check("wrap_ww", {52'b0, ww_a}, 64'd12);

    // back-pressure with valid held high across two beats
    pulse_clear_a();
    d0 = done_cnt_a;
    bp_beats[0] = 64'hA004_A003_A002_A001;
    bp_beats[1] = 64'hB004_B003_B002_B001;
    for (int w = 0; w < 4; w++) push_a(w, 0, 16'(16'hA001 + w));
    for (int w = 0; w < 4; w++) push_a(w, 1, 16'(16'hB001 + w));
    hs = 0; t0 = 0; t1 = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (hs == 2) begin valid_a = 1'b0; break; end
      valid_a = 1'b1; last_a = 1'b0;
      if (ready_a) begin
        data_a = bp_beats[hs];
        if (hs == 0) t0 = cyc; else t1 = cyc;
        hs++;
      end else begin
        data_a = {$urandom, $urandom};
        last_a = 1'($urandom);
      end
    end
    valid_a = 1'b0; last_a = 1'b0;
    check("bp_handshakes", hs, 2);
    check("bp_spacing", t1 - t0, 5);
    repeat (6) tick();
    check("bp_ww", {52'b0, ww_a}, 64'd8);
    check("bp_no_done", done_cnt_a, d0);

    // clear in the middle of unpacking
    pulse_clear_a();
    d0 = done_cnt_a;
    push_a(0, 0, 16'hC001); push_a(1, 0, 16'hC002);
    send_a(64'hC004_C003_C002_C001, 1'b1);
    repeat (3) tick();
    clear_a = 1'b1;
    check("ready_low_during_clear", {63'b0, ready_a}, 64'h0);
    tick();
    clear_a = 1'b0;
    repeat (8) tick();
    check("clear_no_done", done_cnt_a, d0);
    check("clear_ww", {52'b0, ww_a}, 64'h0);
    check("clear_ovf", {63'b0, ovf_a}, 64'h0);
    for (int w = 0; w < 4; w++) push_a(w, 0, 16'(16'hD001 + w));
    send_a(64'hD004_D003_D002_D001, 1'b1);
    wait_done_a();
    check("after_clear_ww", {52'b0, ww_a}, 64'd4);

    // overflow on two-deep banks
    for (int b = 0; b < 2; b++)
      for (int w = 0; w < 4; w++) push_b(w, b, 16'(16'hF000 + 16'h0100 * b + w));
    send_b(64'hF003_F002_F001_F000, 1'b0);
    send_b(64'hF103_F102_F101_F100, 1'b0);
    repeat (5) tick();
    check("ovf_clear_before_full", {63'b0, ovf_b}, 64'h0);
    send_b(64'hF203_F202_F201_F200, 1'b1);
    wait_done_b();
    check("ovf_set", {63'b0, ovf_b}, 64'h1);
    check("ovf_ww", {60'b0, ww_b}, 64'd8);
    repeat (5) tick();
    check("ovf_sticky", {63'b0, ovf_b}, 64'h1);
    check("ovf_done_once", done_cnt_b, 1);
    tick(); clear_b = 1'b1;
    tick(); clear_b = 1'b0;
    check("ovf_cleared", {63'b0, ovf_b}, 64'h0);
    check("ovf_ww_cleared", {60'b0, ww_b}, 64'h0);

    // asynchronous reset while unpacking
    push_a(0, 0, 16'hE001);
    send_a(64'hE004_E003_E002_E001, 1'b1);
    repeat (2) tick();
    check("strobe_before_reset", {60'b0, en_a}, 64'h1);
    reset = 1'b1;
    #1;
    check("reset_async_en", {60'b0, en_a}, 64'h0);
    check("reset_async_addr", {55'b0, addr_a}, 64'h0);
    check("reset_async_data", {48'b0, wdata_a}, 64'h0);
    tick();
    reset = 1'b0;
    tick();
    check("post_reset_ovf", {63'b0, ovf_a}, 64'h0);
    check("post_reset_ww", {52'b0, ww_a}, 64'h0);
    check("post_reset_ready", {63'b0, ready_a}, 64'h1);
    for (int w = 0; w < 4; w++) push_a(w, 0, 16'(16'h5501 + w));
    send_a(64'h5504_5503_5502_5501, 1'b1);
    wait_done_a();
    check("post_reset_ww4", {52'b0, ww_a}, 64'd4);

    repeat (5) tick();
    check("queue_a_drained", exp_a.size(), 0);
    check("queue_b_drained", exp_b.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axis_weight_memory_writer.md
# axis_weight_memory_writer

Parametrised AXI-stream to banked weight-memory writer. Accepts weight beats on a ready/valid/last stream, unpacks each beat into `WEIGHT_WORD_BIT_WIDTH` words (LSB word first) and writes them round-robin across `N_BANKS` weight-memory banks, one word per cycle. It reports transfer completion, a written-word count and a sticky overflow flag. It sits between the DMA stream and the weight memory banks of the convolution engine.

## Interface
- `AXIS_BUS_BIT_WIDTH`, 64, stream data width; must be an integer multiple of `WEIGHT_WORD_BIT_WIDTH`.
- `WEIGHT_WORD_BIT_WIDTH`, 16, width of one weight-memory word.
- `N_BANKS`, 4, number of weight-memory banks; must be at least 1.
- `BANK_DEPTH`, 512, words per bank.
- Derived parameters:
  - `WORDS_PER_BEAT = AXIS_BUS_BIT_WIDTH / WEIGHT_WORD_BIT_WIDTH`
  - `ADDR_W = max(1, clog2(BANK_DEPTH))`
  - `CNT_W = clog2(N_BANKS*BANK_DEPTH + 1)`
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `clear` in 1: synchronous abort and restart of the write pointers.
- `s_axis_data` in `AXIS_BUS_BIT_WIDTH`: beat data.
- `s_axis_valid` in 1: beat valid.
- `s_axis_last` in 1: final beat of a weight transfer.
- `s_axis_ready` out 1: beat accepted when `valid & ready`.
- `wm_wr_en` out `N_BANKS`: one-hot bank write strobe.
- `wm_wr_addr` out `ADDR_W`: write address, shared by all banks.
- `wm_wr_data` out `WEIGHT_WORD_BIT_WIDTH`: write data, shared by all banks.
- `done` out 1: one-cycle pulse after the final word of a `last` beat has been handled.
- `overflow` out 1: sticky; a word arrived after the memory was full.
- `words_written` out `CNT_W`: number of words actually written since the last `clear` or `reset`.

## Operation
- State machine with three states:
  - IDLE: `s_axis_ready = ~clear`.
    - On `valid & ready`, capture data into the unpack register and the `last` bit into `beat_last`; set `word_idx = 0`; go to UNPACK.
  - UNPACK: each cycle, handle word `word_idx` (bits `[word_idx*W +: W]`).
    - If not full: `wm_wr_en[bank_ptr] = 1`, `wm_wr_addr = addr_ptr`, `wm_wr_data` = the word. Then increment `words_written`. Then advance `bank_ptr`; on wrap from `N_BANKS-1` to 0, increment `addr_ptr`.
    - If full: no strobe; set `overflow`.
    - When `word_idx == WORDS_PER_BEAT-1`: go to DONE if `beat_last`, else to IDLE. Otherwise increment `word_idx`.
  - DONE: `done = 1` for one cycle; `bank_ptr`, `addr_ptr` and `word_idx` reset to 0; go to IDLE. `words_written` and `overflow` hold until `clear`.
- Full condition: a write occurred at `bank_ptr == N_BANKS-1` and `addr_ptr == BANK_DEPTH-1`. This sets an internal `full` flag; pointers do not wrap.
  - `full` is cleared by DONE, `clear` or `reset`.
- Overflow: the stream is still consumed so the DMA never stalls, but no memory writes occur.
- `clear` has priority over everything, in any state. It returns to IDLE and zeroes the pointers, `full`, `overflow` and `words_written`. Any captured beat is dropped and no `done` is produced.
  - A beat presented in the same cycle as `clear` is not accepted, because ready is low that cycle.
- Arithmetic: `words_written` never exceeds `N_BANKS*BANK_DEPTH`, so it cannot wrap.

## Timing
- Reset values: `s_axis_ready = 1` (IDLE, `clear` low), `wm_wr_en = 0`, `wm_wr_addr = 0`, `wm_wr_data = 0`, `done = 0`, `overflow = 0`, `words_written = 0`; state is IDLE.
- `wm_wr_*`, `done` and `overflow` are registered outputs. `s_axis_ready` is state-decoded gated by `clear`.
- Latency:
  - The first word's strobe is seen one cycle after the handshake.
  - Word k's strobe is seen k+1 cycles after the handshake.
- Throughput: one beat per `WORDS_PER_BEAT+1` cycles. Ready is low for the whole of UNPACK and DONE.
- `done` is seen `WORDS_PER_BEAT+1` cycles after the `last` handshake.
- Writes on the following transfer start again at bank 0, address 0.
- `reset` asserted mid-UNPACK: outputs go to their reset values immediately (asynchronously); no further strobes occur.
- `s_axis_data` and `s_axis_last` are sampled only on the handshake. Changes while ready is low are ignored.

## Test plan
- Basic write (defaults): one beat `0x4444_3333_2222_1111` with `last`.
  - Required: strobes in order `wm_wr_en` = 0001/0010/0100/1000, all at addr 0, with data 1111, 2222, 3333, 4444.
  - Then `done` one cycle later and `words_written = 4`.
- Round-robin wrap: 3 beats, last on the third.
  - Required: 12 writes; addr 0,1,2 each covering banks 0..3 in order; `done` once; `words_written = 12`.
- Overflow (`BANK_DEPTH = 2`, `N_BANKS = 4`): 3 beats with last.
  - Required: 8 writes, then 4 words produce no strobe; `overflow = 1`; `words_written = 8`; `done` still pulses; `overflow` holds until `clear`.
- Back-pressure: valid held high continuously for 2 beats.
  - Required: ready high only in IDLE; the handshakes are `WORDS_PER_BEAT+1 = 5` cycles apart; data is not corrupted by toggling the stream data while ready is low.
- Clear mid-UNPACK after 2 words:
  - Required: no further strobes and no `done`; counters are zero.
  - The next beat writes bank 0, addr 0.
- Asynchronous reset mid-UNPACK:
  - Required: `wm_wr_en` drops the same cycle.
  - After release, the first beat writes bank 0, addr 0.
  - `overflow = 0` and `words_written = 0`.
